// File: rtl/serial_adder_ctrl_if.sv
// Bundle between a serial add/subtract requester, the controller and the
// external shared 1-bit full adder.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             fa_sum;
  logic             fa_cout;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  // The master side is the environment: requester plus the full adder cell.
  modport master (
    output start, sub, op_a, op_b, fa_sum, fa_cout,
    input  fa_a, fa_b, fa_cin, busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b, fa_sum, fa_cout,
    output fa_a, fa_b, fa_cin, busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit two's-complement add/subtract controller that time-shares
// one external 1-bit full adder, LSB first, one bit per clock.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_sr_d   = bus.op_a;
          b_sr_d   = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d  = bus.sub;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d = {bus.fa_sum, result_q[WIDTH-1:1]};
        carry_d  = bus.fa_cout;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ bus.fa_cout;
          cout_d  = bus.fa_cout;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Full adder inputs are forced low outside RUN so the shared cell sees no activity.
  assign bus.fa_a   = (state_q == RUN) & a_sr_q[0];
  assign bus.fa_b   = (state_q == RUN) & b_sr_q[0];
  assign bus.fa_cin = (state_q == RUN) & carry_q;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule
